// File: rtl/tiny_dnn_seq.sv
// tiny_dnn_seq: per-neuron sequencer driving tiny_dnn_core and normalize.
// Streams n weight/input addresses, issues the bias step, drains the FMA,
// strobes normalize, rounds its fp32 result to bfloat16 (optional ReLU) and
// presents it on a valid/ready port.
module tiny_dnn_seq #(
  parameter int unsigned F_SIZE = 1024,
  localparam int unsigned AW = $clog2(F_SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] n,
  input  logic          relu,
  output logic          init,
  output logic          exec,
  output logic          bias,
  output logic [AW-1:0] ra,
  output logic          nrm_en,
  input  logic [31:0]   nrm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_data,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_EXEC,
    S_BIAS,
    S_DRAIN,
    S_NORM,
    S_CAP,
    S_OUT
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] n_q;
  logic [AW-1:0] n_next;
  logic          relu_q;
  logic          relu_next;
  logic          init_next;
  logic          exec_next;
  logic          bias_next;
  logic          nrm_en_next;
  logic          out_valid_next;
  logic          busy_next;
  logic [AW-1:0] ra_next;
  logic [15:0]   out_data_next;
  logic [15:0]   bf16_c;

  // Round fp32 to bf16 (nearest-even; carry may ripple into exponent), then ReLU
  always_comb begin
    bf16_c = nrm[31:16] + 16'(nrm[15] & (nrm[16] | (|nrm[14:0])));
    if (relu_q && nrm[31]) begin
      bf16_c = 16'h0000;
    end
  end

  // Next-state and next-output decode; strobes are registered from state_next
  always_comb begin
    state_next    = state;
    n_next        = n_q;
    relu_next     = relu_q;
    ra_next       = '0;
    out_data_next = out_data;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_INIT;
          n_next     = n;
          relu_next  = relu;
        end
      end
      S_INIT:  state_next = (n_q != '0) ? S_EXEC : S_BIAS;
      S_EXEC: begin
        if (ra == n_q - AW'(1)) begin
          state_next = S_BIAS;
        end else begin
          ra_next = ra + AW'(1);
        end
      end
      S_BIAS:  state_next = S_DRAIN;
      S_DRAIN: state_next = S_NORM;
      S_NORM:  state_next = S_CAP;
      S_CAP: begin
        state_next    = S_OUT;
        out_data_next = bf16_c;
      end
      S_OUT: begin
        if (out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    init_next      = (state_next == S_INIT);
    exec_next      = (state_next == S_EXEC);
    bias_next      = (state_next == S_BIAS);
    nrm_en_next    = (state_next == S_NORM);
    out_valid_next = (state_next == S_OUT);
    busy_next      = (state_next != S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      n_q       <= '0;
      relu_q    <= 1'b0;
      init      <= 1'b0;
      exec      <= 1'b0;
      bias      <= 1'b0;
      nrm_en    <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      ra        <= '0;
      out_data  <= 16'h0000;
    end else begin
      state     <= state_next;
      n_q       <= n_next;
      relu_q    <= relu_next;
      init      <= init_next;
      exec      <= exec_next;
      bias      <= bias_next;
      nrm_en    <= nrm_en_next;
      out_valid <= out_valid_next;
      busy      <= busy_next;
      ra        <= ra_next;
      out_data  <= out_data_next;
    end
  end

endmodule

// File: tb/tb_tiny_dnn_seq.sv
// tb_tiny_dnn_seq: directed bench with a timeline model of the sequencer and a
// real-valued stand-in for the core/normalize datapath.
module tb_tiny_dnn_seq;

  localparam int unsigned F_SIZE = 1024;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] n;
  logic          relu;
  logic          init;
  logic          exec;
  logic          bias;
  logic [AW-1:0] ra;
  logic          nrm_en;
  logic [31:0]   nrm;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_data;
  logic          busy;

  tiny_dnn_seq #(.F_SIZE(F_SIZE)) dut (
    .clk(clk), .reset(reset), .start(start), .n(n), .relu(relu),
    .init(init), .exec(exec), .bias(bias), .ra(ra), .nrm_en(nrm_en),
    .nrm(nrm), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int          tests;
  int          fails;
  int          cyc;
  int          last_start;
  logic [15:0] wmem [F_SIZE];
  real         d_val;
  real         acc;
  logic        ovr_en;
  logic [31:0] ovr_val;
  bit          m_act;
  int          s_m;
  int          n_m;
  bit          relu_m;
  logic [15:0] data_m;
  int          exec_seen;
  int          bias_seen;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, req);
    end
  endtask

  function automatic real bf16_to_real(input logic [15:0] w);
    logic [63:0] b;
    if (w[14:7] == 8'd0) return 0.0;
    b = {w[15], 11'(int'(w[14:7]) + 896), w[6:0], 45'd0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [31:0] real_to_fp32(input real r);
    logic [63:0] b;
    int e;
    if (r == 0.0) return 32'd0;
    b = $realtobits(r);
    e = int'(b[62:52]) - 896;
    return {b[63], 8'(e), b[51:29]};
  endfunction

  function automatic logic [15:0] to_bf16(input logic [31:0] x, input bit rl);
    int unsigned low;
    int unsigned hi;
    low = 32'(x[15:0]);
    hi  = 32'(x[31:16]);
    if (rl && x[31]) return 16'h0000;
    if (low > 32'h8000 || (low == 32'h8000 && hi[0])) hi = hi + 1;
    return 16'(hi);
  endfunction

  // Per-cycle compare against the timeline model, then advance model and datapath stand-in
  task automatic cycle_check();
    int k;
    bit e_init, e_exec, e_bias, e_nrm, e_val, e_busy;
    logic [AW-1:0] e_ra;
    k = cyc - s_m;
    e_init = 0; e_exec = 0; e_bias = 0; e_nrm = 0; e_val = 0; e_busy = 0;
    e_ra = '0;
    if (m_act) begin
      e_busy = 1;
      e_init = (k == 1);
      e_exec = (k >= 2 && k <= n_m + 1);
      if (e_exec) e_ra = AW'(k - 2);
      e_bias = (k == n_m + 2);
      e_nrm  = (k == n_m + 4);
      e_val  = (k >= n_m + 6);
    end
    check("init", 32'(init), 32'(e_init));
    check("exec", 32'(exec), 32'(e_exec));
    check("bias", 32'(bias), 32'(e_bias));
    check("ra", 32'(ra), 32'(e_ra));
    check("nrm_en", 32'(nrm_en), 32'(e_nrm));
    check("out_valid", 32'(out_valid), 32'(e_val));
    check("busy", 32'(busy), 32'(e_busy));
    check("out_data", 32'(out_data), 32'(data_m));
    if (exec === 1'b1) exec_seen++;
    if (bias === 1'b1) bias_seen++;
    if (init === 1'b1) acc = 0.0;
    if (exec === 1'b1) acc += bf16_to_real(wmem[ra]) * d_val;
    if (bias === 1'b1) acc += bf16_to_real(wmem[F_SIZE-1]);
    if (m_act && k == n_m + 5) data_m = to_bf16(nrm, relu_m);
    if (nrm_en === 1'b1) nrm = ovr_en ? ovr_val : real_to_fp32(acc);
    if (reset) begin
      m_act  = 0;
      data_m = 16'h0000;
    end else if (m_act && e_val && out_ready) begin
      m_act = 0;
    end else if (!m_act && start) begin
      m_act  = 1;
      s_m    = cyc;
      n_m    = int'(n);
      relu_m = relu;
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    #1;
  endtask

  task automatic run_neuron(input int nn, input bit rl, input logic [15:0] req, input string name);
    int lat;
    n = AW'(nn);
    relu = rl;
    start = 1'b1;
    last_start = cyc;
    tick();
    start = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
    check({name, "_lat"}, 32'(lat), 32'(nn + 6));
    check({name, "_data"}, 32'(out_data), 32'(req));
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int e0, b0, g, t0, lat;
    tests = 0; fails = 0; cyc = 0; last_start = 0;
    reset = 1'b1; start = 1'b0; n = '0; relu = 1'b0; out_ready = 1'b1;
    nrm = 32'd0; ovr_en = 1'b0; ovr_val = 32'd0; d_val = 2.0; acc = 0.0;
    m_act = 0; s_m = 0; n_m = 0; relu_m = 0; data_m = 16'h0000;
    exec_seen = 0; bias_seen = 0;
    for (int i = 0; i < int'(F_SIZE); i++) wmem[i] = 16'h0000;
    tick(); tick(); tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_ra", 32'(ra), 32'd0);

    // 3 x (1.0 * 2.0) + 0.5 = 6.5
    wmem[0] = 16'h3F80; wmem[1] = 16'h3F80; wmem[2] = 16'h3F80;
    wmem[F_SIZE-1] = 16'h3F00;
    e0 = exec_seen; b0 = bias_seen;
    run_neuron(3, 1'b0, 16'h40D0, "dot3");
    check("dot3_exec_count", 32'(exec_seen - e0), 32'd3);
    check("dot3_bias_count", 32'(bias_seen - b0), 32'd1);

    // bias only, with and without ReLU
    wmem[F_SIZE-1] = 16'hBF80;
    run_neuron(0, 1'b0, 16'hBF80, "n0_neg");
    run_neuron(0, 1'b1, 16'h0000, "n0_relu");

    // rounding cases with normalize output forced
    ovr_en = 1'b1;
    ovr_val = 32'h3F808000; run_neuron(0, 1'b0, 16'h3F80, "rnd_tie_even");
    ovr_val = 32'h3F818000; run_neuron(0, 1'b0, 16'h3F82, "rnd_tie_odd");
    ovr_val = 32'h3F808001; run_neuron(0, 1'b0, 16'h3F81, "rnd_sticky");
    ovr_val = 32'h00000000; run_neuron(0, 1'b0, 16'h0000, "rnd_zero");
    ovr_val = 32'h7F7F8000; run_neuron(0, 1'b0, 16'h7F80, "rnd_carry_inf");
    ovr_en = 1'b0;

    // backpressure: five stalled cycles, start pulses ignored, handshake on the sixth
    wmem[F_SIZE-1] = 16'h4040;
    out_ready = 1'b0; n = '0; relu = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
    check("bp_lat", 32'(lat), 32'd6);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_busy", 32'(busy), 32'd1);
      check("bp_hold", 32'(out_data), 32'h4040);
      start = (i % 2 == 1);
      n = AW'(5);
      tick();
    end
    start = 1'b1;
    out_ready = 1'b1;
    check("bp_valid_hs", 32'(out_valid), 32'd1);
    tick();
    start = 1'b0;
    check("bp_idle_busy", 32'(busy), 32'd0);
    check("bp_idle_valid", 32'(out_valid), 32'd0);
    tick();
    check("bp_no_restart_busy", 32'(busy), 32'd0);
    check("bp_no_restart_init", 32'(init), 32'd0);

    // reset in the middle of EXEC, then a fresh n=1 neuron: 1.0*2.0 + 0.5 = 2.5
    for (int i = 0; i < 10; i++) wmem[i] = 16'h3F80;
    wmem[F_SIZE-1] = 16'h3F00;
    n = AW'(10); start = 1'b1;
    tick();
    start = 1'b0;
    g = 0;
    while (!(exec === 1'b1 && ra == AW'(4)) && g < 30) begin
      tick();
      g++;
    end
    check("rx_at_ra4", 32'(ra), 32'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rx_exec", 32'(exec), 32'd0);
    check("rx_ra", 32'(ra), 32'd0);
    check("rx_busy", 32'(busy), 32'd0);
    check("rx_data", 32'(out_data), 32'd0);
    run_neuron(1, 1'b0, 16'h4020, "rx_n1");

    // back-to-back: 2*2+2*2+1 = 9.0, then 2*2+1 = 5.0
    wmem[0] = 16'h4000; wmem[1] = 16'h4000; wmem[F_SIZE-1] = 16'h3F80;
    run_neuron(2, 1'b0, 16'h4110, "b2b_first");
    t0 = last_start;
    run_neuron(1, 1'b0, 16'h40A0, "b2b_second");
    check("b2b_throughput", 32'(last_start - t0), 32'd9);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
